// File: rtl/timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared countdown timer.
package timer_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 26;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bus of the shared timer: request/period in, grant/done/status out.
interface timer_arbiter_if import timer_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) ();
  logic [NUM_REQ-1:0]       i_req;
  logic [NUM_REQ*CNT_W-1:0] i_period;
  logic [NUM_REQ-1:0]       o_grant;
  logic [NUM_REQ-1:0]       o_done;
  logic                     o_busy;
  logic [CNT_W-1:0]         o_count;

  modport master (output i_req, i_period, input o_grant, o_done, o_busy, o_count);
  modport slave  (input i_req, i_period, output o_grant, o_done, o_busy, o_count);
endinterface

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_vld
);
  always_comb begin
    logic [IDX_W-1:0] k;
    k       = '0;
    o_grant = '0;
    o_idx   = '0;
    o_vld   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_vld && i_req[k]) begin
        o_vld = 1'b1;
        o_idx = k;
      end
    end
    if (o_vld) o_grant[o_idx] = 1'b1;
  end
endmodule

// File: rtl/timer_arbiter.sv
// One countdown timer time-shared by NUM_REQ requesters; owner chosen round-robin,
// released on expiry (one-cycle done pulse) or when the owner drops its request.
module timer_arbiter import timer_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           i_clk,
  input  logic           i_reset,
  timer_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][CNT_W-1:0] w_per;
  state_t                        r_state, w_state_nxt;
  logic [IDX_W-1:0]              r_win, r_ptr, w_arb_idx;
  logic [NUM_REQ-1:0]            w_arb_gnt, w_win_oh, w_grant_nxt, w_done_nxt;
  logic [NUM_REQ-1:0]            r_grant, r_done;
  logic                          w_arb_vld, w_req_own, r_busy;
  logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;

  assign w_per     = bus.i_period;
  assign w_win_oh  = NUM_REQ'(1) << r_win;
  assign w_req_own = bus.i_req[r_win];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req   (bus.i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_vld   (w_arb_vld)
  );

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;

  // Owner dropping its request wins over expiry: abort, never a done pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_arb_vld) w_state_nxt = LOAD;
      LOAD: if (!w_req_own)          w_state_nxt = IDLE;
            else if (w_per[r_win] == '0) w_state_nxt = DONE;
            else                     w_state_nxt = RUN;
      RUN:  if (!w_req_own)          w_state_nxt = IDLE;
            else if (r_cnt <= CNT_W'(1)) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; counter is zero outside LOAD/RUN
  // and the period is captured on the LOAD->RUN edge only.
  always_comb begin
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_cnt_nxt   = '0;
    case (w_state_nxt)
      LOAD: w_grant_nxt = w_arb_gnt;
      RUN: begin
        w_grant_nxt = w_win_oh;
        w_cnt_nxt   = (r_state == LOAD) ? w_per[r_win] : r_cnt - CNT_W'(1);
      end
      DONE: w_done_nxt = w_win_oh;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_win   <= '0;
      r_ptr   <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && w_arb_vld) r_win <= w_arb_idx;
      if ((r_state == LOAD || r_state == RUN) && w_state_nxt != RUN)
        r_ptr <= IDX_W'(wrap_inc(int'(r_win), NUM_REQ));
    end

  assign bus.o_grant = r_grant;
  assign bus.o_done  = r_done;
  assign bus.o_busy  = r_busy;
  assign bus.o_count = r_cnt;
endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboarded bench: expected done pulses queued at stimulus time, popped by a monitor.
module tb_timer_arbiter;
  import timer_arb_pkg::*;
  localparam int NR = 4;
  localparam int CW = 12;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  int   cyc = 0, n_chk = 0, n_err = 0;

  timer_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();
  timer_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {logic [NR-1:0] vec; int cyc;} exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input logic [NR-1:0] g, input logic b, input logic [CW-1:0] c);
    chk({tag, "_gnt"},  bus.o_grant, g);
    chk({tag, "_busy"}, bus.o_busy,  b);
    chk({tag, "_cnt"},  bus.o_count, c);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge i_clk);
  endtask

  task automatic set_per(input int k, input logic [CW-1:0] v);
    bus.i_period[k*CW +: CW] = v;
  endtask

  function automatic logic [NR-1:0] oh(input int k);
    return NR'(1) << k;
  endfunction

  always @(negedge i_clk)
    if (bus.o_done != '0) begin
      if (sb.size() == 0) chk("unexp_done", bus.o_done, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_vec", bus.o_done, e.vec);
        chk("done_cyc", cyc, e.cyc);
        chk("done_gnt", bus.o_grant, 0);
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_req    = '0;
    bus.i_period = '0;
    repeat (3) @(negedge i_clk);
    chk_out("rst", 0, 0, 0);
    chk("rst_done", bus.o_done, 0);
    i_reset = 1'b0;

    // single requester, period 5
    @(negedge i_clk);
    set_per(0, 5); bus.i_req = 4'b0001; n = cyc + 1;
    sb.push_back('{4'b0001, n + 6});
    wait_to(n); chk_out("t1_load", 4'b0001, 1, 0);
    for (int j = 1; j <= 5; j++) begin
      wait_to(n + j); chk_out("t1_run", 4'b0001, 1, CW'(6 - j));
    end
    wait_to(n + 6); bus.i_req = '0; chk_out("t1_done", 0, 1, 0);
    wait_to(n + 7); chk_out("t1_idle", 0, 0, 0);

    // all requesting, period 2, ptr back to 0
    i_reset = 1'b1; @(negedge i_clk); i_reset = 1'b0;
    for (int k = 0; k < NR; k++) set_per(k, 2);
    bus.i_req = '1; n = cyc + 1;
    for (int k = 0; k < 5; k++) sb.push_back('{oh(k % NR), n + 3 + 5*k});
    for (int k = 0; k < 5; k++) begin
      wait_to(n + 5*k);     chk("t2_gnt", bus.o_grant, oh(k % NR));
      wait_to(n + 5*k + 1); chk("t2_cnt", bus.o_count, 2);
      wait_to(n + 5*k + 3); if (k == 4) bus.i_req = '0;
      wait_to(n + 5*k + 4); chk_out("t2_gap", 0, 0, 0);
    end

    // zero period on requester 1 (ptr is 1)
    set_per(1, 0); bus.i_req = 4'b0010; n = cyc + 1;
    sb.push_back('{4'b0010, n + 1});
    wait_to(n);     chk_out("t3_load", 4'b0010, 1, 0);
    wait_to(n + 1); bus.i_req = '0; chk_out("t3_done", 0, 1, 0);
    wait_to(n + 2); chk_out("t3_idle", 0, 0, 0);

    // abort requester 2 after 3 RUN cycles
    set_per(2, 10); bus.i_req = 4'b0100; n = cyc + 1;
    wait_to(n); chk_out("t4_load", 4'b0100, 1, 0);
    for (int j = 1; j <= 3; j++) begin
      wait_to(n + j); chk("t4_cnt", bus.o_count, 11 - j);
    end
    bus.i_req = '0;
    wait_to(n + 4); chk_out("t4_abort", 0, 0, 0); chk("t4_nodone", bus.o_done, 0);
    set_per(3, 1); bus.i_req = '1; n = cyc + 1;
    sb.push_back('{4'b1000, n + 2});
    wait_to(n); chk("t4_ptr3", bus.o_grant, 4'b1000);
    wait_to(n + 2); bus.i_req = '0;
    wait_to(n + 3);

    // reset mid-RUN, then requester 0 favoured
    set_per(0, 10); bus.i_req = 4'b0001; n = cyc + 1;
    wait_to(n + 4); chk("t5_cnt7", bus.o_count, 7);
    #1 i_reset = 1'b1;
    #1 chk_out("t5_rst", 0, 0, 0); chk("t5_rst_done", bus.o_done, 0);
    @(negedge i_clk);
    set_per(0, 1); set_per(3, 1); bus.i_req = 4'b1001; i_reset = 1'b0; n = cyc + 1;
    sb.push_back('{4'b0001, n + 2});
    sb.push_back('{4'b1000, n + 6});
    wait_to(n);     chk("t5_first", bus.o_grant, 4'b0001);
    wait_to(n + 4); chk("t5_second", bus.o_grant, 4'b1000);
    wait_to(n + 6); bus.i_req = '0;
    wait_to(n + 7);

    // full-scale period, period input changed mid-run
    set_per(3, '1); bus.i_req = 4'b1000; n = cyc + 1;
    sb.push_back('{4'b1000, n + 4096});
    wait_to(n + 1); chk("t6_cnt_max", bus.o_count, 12'hfff);
    set_per(3, 5);
    wait_to(n + 2);    chk("t6_cnt_m1", bus.o_count, 12'hffe);
    wait_to(n + 2000); chk("t6_cnt_mid", bus.o_count, 2096);
    wait_to(n + 4095); chk("t6_cnt_one", bus.o_count, 1);
    wait_to(n + 4096); bus.i_req = '0; chk_out("t6_done", 0, 1, 0);
    wait_to(n + 4097); chk_out("t6_idle", 0, 0, 0);

    repeat (3) @(negedge i_clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the countdown timer.
REQ-002 Parameter CNT_W, default 26, timer width in bits, enough for 50,000,000 cycles.
REQ-003 Port i_clk, input, 1, clock; all state changes on rising edge.
REQ-004 Port i_reset, input, 1, reset; asynchronous, active-high.
REQ-005 Port i_req, input, NUM_REQ, level request per requester; held high until its o_done.
REQ-006 Port i_period, input, NUM_REQ*CNT_W, packed per-requester delay in cycles; slice k = bits [k*CNT_W +: CNT_W].
REQ-007 Port o_grant, output, NUM_REQ, one-hot owner of the timer; all-zero when unowned.
REQ-008 Port o_done, output, NUM_REQ, one-cycle pulse to the owner when its delay expires.
REQ-009 Port o_busy, output, 1, high whenever the state is not IDLE.
REQ-010 Port o_count, output, CNT_W, remaining count of the running delay.

Function
REQ-011 FSM states: IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-012 IDLE: if any i_req is high, pick winner W round-robin starting at ptr, latch W, go to LOAD; else stay in IDLE.
REQ-013 LOAD: o_grant = onehot(W); counter <= i_period[W]; if i_period[W] == 0 go to DONE, else go to RUN.
REQ-014 RUN: decrement the counter each cycle; when counter == 1, counter <= 0 and go to DONE; RUN lasts exactly P cycles.
REQ-015 DONE: o_done[W] = 1 for exactly one cycle, o_grant = 0, ptr <= W+1 modulo NUM_REQ, go to IDLE.
REQ-016 Latency: with i_req[W] first sampled high at edge N and the timer free, LOAD is at N+1, RUN at N+2..N+P+1, and o_done[W] is high in cycle N+P+2 (N+2 when P = 0).
REQ-017 Abort: i_req[W] low while in LOAD or RUN -> next state IDLE, o_grant = 0, counter = 0, no o_done, ptr <= W+1.
REQ-018 i_period[W] is sampled only in LOAD; changes during RUN are ignored.
REQ-019 Requests from non-owners are ignored until IDLE; no request is lost while held high.
REQ-020 There is exactly one IDLE cycle between consecutive grants; a held requester waits at most NUM_REQ-1 grants.
REQ-021 ptr wraps from NUM_REQ-1 to 0.
REQ-022 o_count equals the counter in LOAD and RUN; o_count is 0 in IDLE and DONE.
REQ-023 Counter arithmetic is unsigned CNT_W-bit and never underflows.

Reset
REQ-024 Asserting i_reset (async) forces: state IDLE, ptr 0, W 0, counter 0, o_grant 0, o_done 0, o_busy 0, o_count 0.
REQ-025 Reset during RUN abandons the delay with no o_done; the first grant after reset release favours requester 0.

Structure
REQ-026 Shared package timer_arb_pkg holds: state enum (IDLE, LOAD, RUN, DONE), default NUM_REQ, default CNT_W.
REQ-027 Sub-module rr_arbiter: combinational, inputs req vector and ptr; outputs one-hot grant, index and valid.
REQ-028 Counter and FSM stay in timer_arbiter; no other sub-modules.

Verification
REQ-029 i_req=0001, period0=5 -> o_grant=0001 from LOAD, o_count 5,4,3,2,1, o_done=0001 exactly 7 cycles after i_req is sampled, then IDLE.
REQ-030 i_req=1111 held, all periods 2, ptr=0 -> grants in order 0,1,2,3,0, each with one o_done pulse and one IDLE gap.
REQ-031 period1=0, i_req=0010 -> LOAD then DONE; o_done[1] at N+2; RUN never entered.
REQ-032 period2=10, drop i_req[2] after 3 RUN cycles -> IDLE next cycle, no o_done, ptr=3.
REQ-033 Assert i_reset mid-RUN (count 7) -> all outputs 0 immediately; after release with i_req=1001, requester 0 is granted first.
REQ-034 period3=2^CNT_W-1, i_period changed during RUN -> o_count decrements from all-ones unaffected; o_done after full count.
